mesh_result_drain: RTL
======================

# mesh_result_drain

Downstream consumer of the `mesh_db` sorting mesh. When the mesh signals that sorting is complete, the block snapshots all N processing-element words in one cycle. It then streams them out one word per accepted handshake in PE index order (0..N-1) over a valid/ready interface. As each word leaves, the block checks that its address field equals its PE index, which is the mesh's sorted-by-destination invariant, and accumulates error status.

## Interface
- `N`, 64, number of mesh PEs; must equal 2**ADDR_WIDTH
- `ADDR_WIDTH`, 6, address (destination) field width; also the index width
- `DATA_WIDTH`, 6, payload field width
- `WIDTH`, ADDR_WIDTH+DATA_WIDTH, word width; word = {addr, data}, addr in MSBs

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, synchronous, active-low
- `sort_done`  in  1  one-cycle pulse from mesh control: results are valid this cycle
- `result_flat`  in  N*WIDTH  mesh outputs; PE[i] at bits [i*WIDTH +: WIDTH]
- `out_valid`  out  1  out_data/out_index/out_last valid
- `out_ready`  in  1  downstream accepts the current word
- `out_data`  out  WIDTH  current word
- `out_index`  out  ADDR_WIDTH  PE index of current word
- `out_last`  out  1  high with index N-1
- `busy`  out  1  snapshot held, drain in progress
- `drain_done`  out  1  one-cycle pulse after the final transfer
- `addr_err`  out  1  sticky: some word had addr != index since reset
- `err_count`  out  ADDR_WIDTH+1  mismatches in the current/last run (0..N)
- `overrun`  out  1  sticky: sort_done arrived while not IDLE

## Operation
- State machine: IDLE -> DRAIN -> DONE -> IDLE.
- IDLE:
  - On sort_done=1, load snapshot[i] <= result_flat word i for all i, set idx <= 0, clear err_count, and go to DRAIN.
  - Outputs: out_valid=0, busy=0.
- DRAIN:
  - out_valid=1, busy=1, out_data=snapshot[idx], out_index=idx, out_last=(idx==N-1).
  - Transfer occurs on any edge with out_valid & out_ready.
  - On transfer, if out_data[WIDTH-1 -: ADDR_WIDTH] != idx, increment err_count and set addr_err.
  - On transfer with idx<N-1: idx <= idx+1.
  - On transfer with idx==N-1: go to DONE. idx does not wrap.
- DONE: exactly one cycle. drain_done=1, busy=0, out_valid=0. Then go to IDLE.
- sort_done in DRAIN or DONE is ignored: the snapshot is untouched and overrun is set (sticky).
- The snapshot is the only copy. result_flat changing after capture has no effect.
- out_ready while out_valid=0 has no effect.
- err_count cannot overflow: its maximum is N, and its width holds N.

## Timing
- Reset (rst=0 at an edge) values:
  - State IDLE, idx=0.
  - out_valid=0, out_last=0, out_index=0, out_data=0.
  - busy=0, drain_done=0, addr_err=0, err_count=0, overrun=0.
  - Snapshot contents: don't-care.
- Reset mid-drain aborts immediately. Nothing further is emitted until the next sort_done after rst returns to 1.
- sort_done sampled at edge k -> out_valid=1 with out_index=0 in the cycle after edge k. Latency is 1 cycle.
- Throughput: 1 word/cycle with out_ready held high. A full drain is N cycles. drain_done is in cycle N+1 after capture. The earliest next sort_done is accepted the cycle after drain_done.
- Backpressure: while out_valid & !out_ready, out_data, out_index and out_last hold stable and no state changes.
- All outputs are registered or decoded from registered state. There is no combinational path from out_ready or sort_done to any output.
- err_count and addr_err update on the edge of the transfer. Their final value is visible in the drain_done cycle.

## Test plan
- Ideal sorted run:
  - Stimulus: result_flat word i = {i, 63-i}, sort_done pulse, out_ready=1.
  - Required: 64 transfers with out_data={i,63-i}, out_last only at i=63, drain_done 65 cycles after the pulse, err_count=0, addr_err=0.
- Backpressure:
  - Stimulus: same data, out_ready toggled 1,0,0,1 repeating.
  - Required: identical word sequence, outputs stable during stalls, no skips or duplicates.
- Address mismatch:
  - Stimulus: words 5 and 40 carry addr 6 and 0.
  - Required: err_count=2 at drain_done, addr_err=1. A following clean run gives err_count=0 while addr_err stays 1.
- Overrun:
  - Stimulus: second sort_done at transfer 10, and another in the DONE cycle.
  - Required: overrun=1, output sequence unaffected, the drain completes from the original snapshot.
- Reset mid-drain:
  - Stimulus: rst=0 for one edge after 20 transfers.
  - Required: next cycle out_valid=0, busy=0, all status cleared. A new sort_done restarts at index 0.
- Snapshot isolation:
  - Stimulus: change result_flat every cycle during DRAIN.
  - Required: emitted words equal the values present at the sort_done edge.

Source files
------------

// File: rtl/mesh_result_drain.sv
// Result drain for the mesh_db sorting mesh: snapshots all PE words on sort_done,
// then streams them out in PE order over valid/ready while checking addr == index.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for sort_done, no snapshot in flight
// ST_DRAIN | snapshot held, presenting snapshot[idx] on the output port
// ST_DONE  | single cycle after the final transfer, drain_done asserted
module mesh_result_drain #(
  parameter int N          = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 6,
  parameter int WIDTH      = ADDR_WIDTH + DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sort_done,
  input  logic [N*WIDTH-1:0]    result_flat,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_last,
  output logic                  busy,
  output logic                  drain_done,
  output logic                  addr_err,
  output logic [ADDR_WIDTH:0]   err_count,
  output logic                  overrun
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] IDX_LAST = ADDR_WIDTH'(N - 1);
  localparam logic [ADDR_WIDTH:0]   ERR_ONE  = (ADDR_WIDTH + 1)'(1);

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] idx;
  logic [WIDTH-1:0]      snap [N];
  logic [WIDTH-1:0]      cur_word;
  logic                  capture;
  logic                  xfer;
  logic                  addr_bad;

  assign cur_word = snap[idx];
  assign capture  = (state == ST_IDLE) && sort_done;
  assign xfer     = (state == ST_DRAIN) && out_ready;
  assign addr_bad = (cur_word[WIDTH-1 -: ADDR_WIDTH] != idx);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      addr_err  <= 1'b0;
      err_count <= '0;
      overrun   <= 1'b0;
    end else begin
      // A sort_done outside IDLE is dropped; only the sticky flag records it.
      if (sort_done && (state != ST_IDLE))
        overrun <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (capture) begin
            idx       <= '0;
            err_count <= '0;
            state     <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (xfer) begin
            if (addr_bad) begin
              err_count <= err_count + ERR_ONE;
              addr_err  <= 1'b1;
            end
            if (idx == IDX_LAST)
              state <= ST_DONE;
            else
              idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          idx   <= '0;
          state <= ST_IDLE;
        end
        default: begin
          idx   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Snapshot has no reset: its contents only matter once a capture has loaded it.
  always_ff @(posedge clk) begin
    if (rst && capture) begin
      for (int i = 0; i < N; i++)
        snap[i] <= result_flat[i*WIDTH +: WIDTH];
    end
  end

  assign out_valid  = (state == ST_DRAIN);
  assign busy       = (state == ST_DRAIN);
  assign drain_done = (state == ST_DONE);
  assign out_data   = out_valid ? cur_word : '0;
  assign out_index  = idx;
  assign out_last   = out_valid && (idx == IDX_LAST);

endmodule
